dac_spi_frame_writer: RTL and testbench

// Parametrised multi-channel serial DAC writer; successor to the single-channel DAC8411 driver.

---
 rtl/dac_spi_frame_writer.sv | 172 +++++++++++++++++
 tb/tb_dac_spi_frame_writer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_frame_writer.sv
// rtl/dac_spi_frame_writer.sv - multi-channel serial DAC frame writer
// Shifts {pd, data, zero pad} MSB first per enabled channel on a shared sclk/sdo.
module dac_spi_frame_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int PD_BITS    = 2,
    parameter int FRAME_BITS = 24,
    parameter int NUM_CH     = 2,
    parameter int SCLK_DIV   = 2,
    parameter int SYNC_HIGH  = 4
) (
    input  logic                         clk,
    input  logic                         sreset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [PD_BITS-1:0]           in_pd,
    input  logic [NUM_CH-1:0]            in_ch_en,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         sclk,
    output logic                         sdo,
    output logic [NUM_CH-1:0]            syncn,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int T_MAX = (SCLK_DIV > SYNC_HIGH) ? SCLK_DIV : SYNC_HIGH;
    localparam int TM_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    if (FRAME_BITS < PD_BITS + DATA_WIDTH) begin : g_bad_frame
        $error("FRAME_BITS must be at least PD_BITS+DATA_WIDTH");
    end
    if (SCLK_DIV < 1) begin : g_bad_div
        $error("SCLK_DIV must be at least 1");
    end
    if (SYNC_HIGH < 1) begin : g_bad_sync
        $error("SYNC_HIGH must be at least 1");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $error("NUM_CH must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SHIFT_HI,
        SHIFT_LO,
        GAP,
        DONE
    } state_t;

    state_t                       state;
    logic [NUM_CH*DATA_WIDTH-1:0] data_l;
    logic [PD_BITS-1:0]           pd_l;
    logic [NUM_CH-1:0]            pending;
    logic [CH_W-1:0]              ch;
    logic [FRAME_BITS-1:0]        shreg;
    logic [BC_W-1:0]              bit_cnt;
    logic [TM_W-1:0]              tmr;

    logic                         sel_found;
    logic [CH_W-1:0]              sel_ch;
    logic [FRAME_BITS-1:0]        load_word;

    // Descending scan so the lowest pending channel wins.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        load_word = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pending[k]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(k);
                load_word[FRAME_BITS-1 -: PD_BITS+DATA_WIDTH] =
                    {pd_l, data_l[k*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state      <= IDLE;
            syncn      <= '1;
            sclk       <= 1'b1;
            sdo        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b0;
            pending    <= '0;
            ch         <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            tmr        <= '0;
            data_l     <= '0;
            pd_l       <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        data_l   <= in_data;
                        pd_l     <= in_pd;
                        pending  <= in_ch_en;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SELECT;
                    end
                end
                SELECT: begin
                    if (!sel_found) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        ch      <= sel_ch;
                        shreg   <= load_word;
                        bit_cnt <= BC_W'(FRAME_BITS - 1);
                        tmr     <= '0;
                        syncn   <= ~(NUM_CH'(1) << sel_ch);
                        sclk    <= 1'b1;
                        sdo     <= load_word[FRAME_BITS-1];
                        state   <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tmr == TM_W'(SCLK_DIV - 1)) begin
                        tmr   <= '0;
                        sclk  <= 1'b0;
                        state <= SHIFT_LO;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (tmr == TM_W'(SCLK_DIV - 1)) begin
                        tmr  <= '0;
                        sclk <= 1'b1;
                        if (bit_cnt != '0) begin
                            // Next bit goes out together with the sclk rise.
                            shreg   <= shreg << 1;
                            sdo     <= shreg[FRAME_BITS-2];
                            bit_cnt <= bit_cnt - 1'b1;
                            state   <= SHIFT_HI;
                        end else begin
                            pending <= pending & ~(NUM_CH'(1) << ch);
                            syncn   <= '1;
                            sdo     <= 1'b0;
                            state   <= GAP;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                GAP: begin
                    if (tmr == TM_W'(SYNC_HIGH - 1)) begin
                        tmr   <= '0;
                        state <= SELECT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                DONE: begin
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_frame_writer.sv
// tb/tb_dac_spi_frame_writer.sv - scoreboard bench for dac_spi_frame_writer
// Frames captured by a DAC emulator are checked against expectations queued at accept.
module tb_dac_spi_frame_writer;

    localparam int FB     = 24;
    localparam int PER_CH = 1 + FB * 2 * 2 + 4;

    typedef struct {
        int          ch;
        logic [23:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        sreset = 1'b1;
    logic [31:0] in_data = '0;
    logic [1:0]  in_pd = '0;
    logic [1:0]  in_ch_en = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, sclk, sdo, busy, frame_done;
    logic [1:0]  syncn;

    int n_cmp = 0;
    int n_bad = 0;
    int falls = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    dac_spi_frame_writer dut (
        .clk(clk), .sreset(sreset), .in_data(in_data), .in_pd(in_pd),
        .in_ch_en(in_ch_en), .in_valid(in_valid), .in_ready(in_ready),
        .sclk(sclk), .sdo(sdo), .syncn(syncn), .busy(busy), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // DAC emulator: samples sdo on sclk falls while a syncn is low.
    logic        prev_sclk = 1'b1;
    logic [1:0]  prev_syncn = 2'b11;
    logic [23:0] cap = '0;
    int          nbits = 0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_sclk && !sclk) falls++;
        if (sreset) begin
            cap   = '0;
            nbits = 0;
        end else begin
            if (syncn != 2'b11) chk("one_syncn_low", $countones(~syncn), 1);
            if (prev_sclk && !sclk && syncn != 2'b11) begin
                cap = {cap[22:0], sdo};
                nbits++;
            end
            for (int k = 0; k < 2; k++) begin
                if (!prev_syncn[k] && syncn[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_ch", k, e.ch);
                        chk("frame_bits", nbits, FB);
                        chk("frame_val", cap, e.val);
                    end
                    cap   = '0;
                    nbits = 0;
                end
            end
        end
        prev_sclk  = sclk;
        prev_syncn = syncn;
    end

    task automatic send(input logic [31:0] d, input logic [1:0] pd, input logic [1:0] en,
                        input bit keep, input logic [31:0] nd);
        int   w;
        int   lat;
        bit   found;
        int   nen;
        exp_t e;
        nen = 0;
        for (int k = 0; k < 2; k++) begin
            if (en[k]) begin
                e.ch  = k;
                e.val = {pd, d[k*16 +: 16], 6'b000000};
                exp_q.push_back(e);
                nen++;
            end
        end
        @(negedge clk);
        in_data = d; in_pd = pd; in_ch_en = en; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        if (keep) in_data = nd;
        else in_valid = 1'b0;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 3000) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) chk("busy_after_accept", busy, 1);
            if (keep && lat == 10) chk("bp_in_ready_low", in_ready, 0);
            if (frame_done) found = 1'b1;
        end
        chk("frame_done_latency", lat, nen * PER_CH + 1);
        @(posedge clk);
        #1;
        chk("done_frame_done_low", frame_done, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int w;
        int f0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_syncn", syncn, 2'b11);
        chk("rst_sclk", sclk, 1);
        chk("rst_sdo", sdo, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        sreset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        send(32'h0000_AAAA, 2'b00, 2'b01, 1'b0, '0);
        send(32'hFFFF_00F0, 2'b11, 2'b11, 1'b0, '0);

        f0 = falls;
        send(32'h1234_5678, 2'b01, 2'b00, 1'b0, '0);
        chk("empty_no_sclk", falls, f0);

        send(32'h0000_8001, 2'b10, 2'b01, 1'b1, 32'h5A5A_0000);
        send(32'h5A5A_0000, 2'b10, 2'b10, 1'b0, '0);

        send(32'hC3C3_3C3C, 2'b01, 2'b10, 1'b0, '0);

        // Abort a frame part way through, then check a clean frame follows.
        @(negedge clk);
        in_data = 32'h0000_FFFF; in_pd = 2'b11; in_ch_en = 2'b01; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        f0 = falls;
        w = 0;
        while (falls < f0 + 10 && w < 1000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("abort_reached_10_falls", falls, f0 + 10);
        sreset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_syncn", syncn, 2'b11);
        chk("abort_sclk", sclk, 1);
        f0 = falls;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_sclk", falls, f0);
        sreset = 1'b0;
        send(32'h0000_1357, 2'b01, 2'b01, 1'b0, '0);

        repeat (5) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
